// File: rtl/proc_pkg.sv
// Shared types and defaults for the processor's memory arbiter.
package proc_pkg;

  localparam int unsigned ARB_AW          = 16;
  localparam int unsigned ARB_DW          = 16;
  localparam int unsigned ARB_TIMEOUT_DEF = 64;
  localparam int unsigned ARB_TW_DEF      = 7;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Transaction captured from the winning requester in IDLE.
  typedef struct packed {
    owner_e              owner;
    logic                wr;
    logic [ARB_AW-1:0]   addr;
    logic [ARB_DW-1:0]   wdata;
  } arb_txn_t;

endpackage

// File: rtl/arb_watchdog.sv
// Counts stalled cycles of the active transaction and flags when the
// memory has failed to respond within TIMEOUT cycles.
module arb_watchdog
  import proc_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF,
  parameter int unsigned TW      = ARB_TW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic hit,
  output logic expired
);

  logic [TW-1:0] cnt_q, cnt_d;

  // Saturating stall counter; cleared when a new transaction starts.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run && !hit && (cnt_q != TW'(TIMEOUT))) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the TIMEOUT-th stalled cycle, counting the issue cycle as the first.
  assign expired = run && !hit && (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one multi-cycle memory port between instruction fetch and data access.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise data wins ties.
module mem_arbiter
  import proc_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEF,
  parameter int unsigned TW      = ARB_TW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ARB_AW-1:0] if_addr,
  output logic              if_grant,
  output logic              if_done,
  output logic [ARB_DW-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_wr,
  input  logic [ARB_AW-1:0] dm_addr,
  input  logic [ARB_DW-1:0] dm_wdata,
  output logic              dm_grant,
  output logic              dm_done,
  output logic [ARB_DW-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ARB_AW-1:0] mem_addr,
  output logic [ARB_DW-1:0] mem_wdata,
  input  logic [ARB_DW-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              err
);

  arb_state_e state_q, state_d;
  arb_txn_t   txn_q, txn_d;
  logic       err_q, err_d;
  owner_e     winner_c;
  logic       any_req_c;
  logic       busy_c;
  logic       complete_c;
  logic       owner_req_c;
  logic       wd_clear_c;
  logic       wd_expired_c;

`ifdef MEM_ARB_RR_EN
  owner_e     last_owner_q, last_owner_d;
`endif

  assign any_req_c   = if_req || dm_req;
  assign busy_c      = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT);
  assign complete_c  = busy_c && mem_done;
  assign owner_req_c = (txn_q.owner == OWN_DM) ? dm_req : if_req;
  assign wd_clear_c  = (state_q == ARB_IDLE) && any_req_c;

  // Winner selection; data accesses belong to older instructions.
  always_comb begin
    winner_c = OWN_IF;
`ifdef MEM_ARB_RR_EN
    if (if_req && dm_req) begin
      if (last_owner_q == OWN_IF) winner_c = OWN_DM;
      else                        winner_c = OWN_IF;
    end else if (dm_req) begin
      winner_c = OWN_DM;
    end
`else
    if (dm_req) winner_c = OWN_DM;
`endif
  end

  arb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear_c),
    .run     (busy_c),
    .hit     (mem_done),
    .expired (wd_expired_c)
  );

  // Next-state, latch and sticky-error logic.
  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    err_d   = err_q;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (mem_done) err_d = 1'b1;
        if (any_req_c) begin
          txn_d.owner = winner_c;
          if (winner_c == OWN_DM) begin
            txn_d.wr    = dm_wr;
            txn_d.addr  = dm_addr;
            txn_d.wdata = dm_wdata;
          end else begin
            txn_d.wr    = 1'b0;
            txn_d.addr  = if_addr;
            txn_d.wdata = '0;
          end
`ifdef MEM_ARB_RR_EN
          last_owner_d = winner_c;
`endif
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE, ARB_WAIT: begin
        if (!owner_req_c) err_d = 1'b1;
        if (mem_done) begin
          state_d = ARB_IDLE;
        end else if (wd_expired_c) begin
          err_d   = 1'b1;
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_WAIT;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      txn_q   <= '0;
      err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_IF;
`endif
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Memory side is driven from the latched transaction.
  assign mem_en    = (state_q == ARB_ISSUE);
  assign mem_wr    = mem_en && txn_q.wr;
  assign mem_addr  = txn_q.addr;
  assign mem_wdata = txn_q.wdata;

  assign if_grant  = busy_c && (txn_q.owner == OWN_IF);
  assign dm_grant  = busy_c && (txn_q.owner == OWN_DM);
  assign if_done   = complete_c && (txn_q.owner == OWN_IF);
  assign dm_done   = complete_c && (txn_q.owner == OWN_DM);
  assign if_rdata  = if_done ? mem_rdata : '0;
  assign dm_rdata  = dm_done ? mem_rdata : '0;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected issues/completions,
// a negedge monitor pops and compares them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        if_grant, if_done;
  logic [15:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_wr = 1'b0;
  logic [15:0] dm_addr = '0;
  logic [15:0] dm_wdata = '0;
  logic        dm_grant, dm_done;
  logic [15:0] dm_rdata;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        err;

  logic gen_done = 1'b0;
  logic stray_done = 1'b0;
  int   mem_lat = 0;
  int   pend = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    int          cy;
    logic        own;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } iss_t;

  typedef struct {
    int          cy;
    logic        own;
    logic        wr;
    logic [15:0] rdata;
  } dn_t;

  iss_t iss_q[$];
  dn_t  dn_q[$];
  iss_t me;
  dn_t  md;

  mem_arbiter #(.TIMEOUT(64), .TW(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_grant  (if_grant),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_wr     (dm_wr),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_grant  (dm_grant),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers mem_lat cycles after mem_en (negative = never), data = addr ^ BEAF.
  assign mem_done  = gen_done | stray_done;
  assign mem_rdata = gen_done ? (mem_addr ^ 16'hBEAF) : 16'h0000;

  always @(posedge clk) begin
    #1;
    gen_done = 1'b0;
    if (mem_en) begin
      if (mem_lat == 0) gen_done = 1'b1;
      else if (mem_lat > 0) pend = mem_lat;
      else pend = 0;
    end else if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) gen_done = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_issue(input int cy, input logic own, input logic wr,
                           input logic [15:0] a, input logic [15:0] wd);
    iss_t e;
    e.cy = cy; e.own = own; e.wr = wr; e.addr = a; e.wdata = wd;
    iss_q.push_back(e);
  endtask

  task automatic exp_done(input int cy, input logic own, input logic wr, input logic [15:0] rd);
    dn_t d;
    d.cy = cy; d.own = own; d.wr = wr; d.rdata = rd;
    dn_q.push_back(d);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // Monitor: every mem_en and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (mem_en) begin
        if (iss_q.size() == 0) begin
          chk("spurious_mem_en", 32'(mem_en), 32'(0));
        end else begin
          me = iss_q.pop_front();
          chk("issue_cycle", 32'(cyc), 32'(me.cy));
          chk("mem_addr", 32'(mem_addr), 32'(me.addr));
          chk("mem_wr", 32'(mem_wr), 32'(me.wr));
          if (me.wr) chk("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
          chk("issue_grant", 32'({if_grant, dm_grant}), me.own ? 32'h1 : 32'h2);
        end
      end
      if (if_done || dm_done) begin
        if (dn_q.size() == 0) begin
          chk("spurious_done", 32'({if_done, dm_done}), 32'(0));
        end else begin
          md = dn_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(md.cy));
          chk("done_owner", 32'({if_done, dm_done}), md.own ? 32'h1 : 32'h2);
          if (md.own) begin
            if (!md.wr) chk("dm_rdata", 32'(dm_rdata), 32'(md.rdata));
            chk("if_rdata_nonowner", 32'(if_rdata), 32'(0));
          end else begin
            chk("if_rdata", 32'(if_rdata), 32'(md.rdata));
            chk("dm_rdata_nonowner", 32'(dm_rdata), 32'(0));
          end
        end
      end else begin
        chk("rdata_idle", 32'({if_rdata, dm_rdata}), 32'(0));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    int c;
    logic own;

    // Reset state
    rst = 1'b1;
    tick(3);
    chk("rst_mem", 32'({mem_en, mem_wr, mem_addr, mem_wdata}), 32'(0));
    chk("rst_if", 32'({if_grant, if_done, if_rdata}), 32'(0));
    chk("rst_dm", 32'({dm_grant, dm_done, dm_rdata}), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    tick(1);

    // Fetch read, memory answers on the 3rd cycle after mem_en
    c = cyc;
    mem_lat = 3; if_req = 1'b1; if_addr = 16'h0040;
    exp_issue(c + 1, 1'b0, 1'b0, 16'h0040, 16'h0000);
    exp_done(c + 4, 1'b0, 1'b0, 16'hBEEF);
    tick(2);
    chk("t1_wait_grant", 32'({if_grant, dm_grant}), 32'h2);
    tick(3);
    if_req = 1'b0;
    tick(1);
    chk("t1_err", 32'(err), 32'(0));

    // Tie: data write first, fetch two cycles later, zero-wait memory
    c = cyc;
    mem_lat = 0;
    if_req = 1'b1; if_addr = 16'h0080;
    dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'h1234;
    exp_issue(c + 1, 1'b1, 1'b1, 16'h0100, 16'h1234);
    exp_done(c + 1, 1'b1, 1'b1, 16'h0000);
    exp_issue(c + 3, 1'b0, 1'b0, 16'h0080, 16'h0000);
    exp_done(c + 3, 1'b0, 1'b0, 16'hBE2F);
    tick(2);
    dm_req = 1'b0; dm_wr = 1'b0;
    tick(2);
    if_req = 1'b0;
    tick(1);

    // Continuous contention for 8 transactions
    c = cyc;
    if_req = 1'b1; if_addr = 16'h0200;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0300;
    for (int i = 0; i < 8; i++) begin
`ifdef MEM_ARB_RR_EN
      own = ((i % 2) == 0);
`else
      own = 1'b1;
`endif
      exp_issue(c + 1 + 2 * i, own, 1'b0, own ? 16'h0300 : 16'h0200, 16'h0000);
      exp_done(c + 1 + 2 * i, own, 1'b0, own ? 16'hBDAF : 16'hBCAF);
    end
    tick(16);
    if_req = 1'b0; dm_req = 1'b0;
    tick(2);
    chk("t3_err", 32'(err), 32'(0));

    // Memory never answers: abort after 64 stalled cycles, no done pulse
    c = cyc;
    mem_lat = -1; if_req = 1'b1; if_addr = 16'h0500;
    exp_issue(c + 1, 1'b0, 1'b0, 16'h0500, 16'h0000);
    tick(63);
    chk("to_c63_grant", 32'(if_grant), 32'(1));
    chk("to_c63_err", 32'(err), 32'(0));
    tick(1);
    chk("to_c64_grant", 32'(if_grant), 32'(1));
    chk("to_c64_err", 32'(err), 32'(0));
    tick(1);
    chk("to_c65_grant", 32'(if_grant), 32'(0));
    chk("to_c65_err", 32'(err), 32'(1));
    if_req = 1'b0;
    tick(5);
    chk("to_err_sticky", 32'(err), 32'(1));
    chk("to_idle_mem_en", 32'(mem_en), 32'(0));
    do_rst();
    chk("to_err_cleared", 32'(err), 32'(0));

    // Stray mem_done while idle
    tick(1);
    chk("stray_pre_err", 32'(err), 32'(0));
    stray_done = 1'b1;
    tick(1);
    stray_done = 1'b0;
    chk("stray_err", 32'(err), 32'(1));
    tick(2);
    chk("stray_err_sticky", 32'(err), 32'(1));
    do_rst();

    // Owner drops dm_req during WAIT: error, transaction still completes
    c = cyc;
    mem_lat = 4; dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0600;
    exp_issue(c + 1, 1'b1, 1'b0, 16'h0600, 16'h0000);
    exp_done(c + 5, 1'b1, 1'b0, 16'hB8AF);
    tick(2);
    dm_req = 1'b0;
    chk("drop_pre_err", 32'(err), 32'(0));
    tick(1);
    chk("drop_err", 32'(err), 32'(1));
    tick(3);
    do_rst();

    // Reset during WAIT, then a fresh fetch proceeds
    c = cyc;
    mem_lat = -1; if_req = 1'b1; if_addr = 16'h0700;
    exp_issue(c + 1, 1'b0, 1'b0, 16'h0700, 16'h0000);
    tick(3);
    chk("rw_pre_grant", 32'(if_grant), 32'(1));
    rst = 1'b1; if_req = 1'b0;
    tick(1);
    chk("rw_mem", 32'({mem_en, mem_wr, mem_addr, mem_wdata}), 32'(0));
    chk("rw_ctl", 32'({if_grant, if_done, dm_grant, dm_done, err}), 32'(0));
    rst = 1'b0;
    c = cyc;
    mem_lat = 2; if_req = 1'b1; if_addr = 16'h0800;
    exp_issue(c + 1, 1'b0, 1'b0, 16'h0800, 16'h0000);
    exp_done(c + 3, 1'b0, 1'b0, 16'hB6AF);
    tick(4);
    if_req = 1'b0;
    tick(3);
    chk("rw_err", 32'(err), 32'(0));

    chk("issue_queue_drained", 32'(iss_q.size()), 32'(0));
    chk("done_queue_drained", 32'(dn_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
